// File: rtl/fetch_npc_stage_pkg.sv
// fetch_npc_stage_pkg: reset constants and npc_sel encodings shared by IF and ID-stage control.
// Rev 1.0
`default_nettype none

package fetch_npc_stage_pkg;

  localparam logic [31:0] C_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] C_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  // Word offset of a conditional branch, sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_npc_stage_npc_calc.sv
// npc_calc: combinational next-PC select (sequential, branch, j/jal, jr).
// Rev 1.0
`default_nettype none

module npc_calc
  import fetch_npc_stage_pkg::*;
(
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_d,
  input  logic [1:0]  i_npc_sel,
  input  logic        i_cmp_true,
  input  logic [15:0] i_imm16_d,
  input  logic [25:0] i_imm26_d,
  input  logic [31:0] i_rs_val_d,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc_seq;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  // Branch and jump targets are relative to the instruction in ID, not to the delay slot in IF.
  assign w_pc_seq    = i_pc_f + 32'd4;
  assign w_br_target = i_pc_d + 32'd4 + branch_offset(i_imm16_d);
  assign w_j_target  = {i_pc_d[31:28], i_imm26_d, 2'b00};

  always_comb begin
    o_npc = w_pc_seq;
    case (npc_sel_e'(i_npc_sel))
      NPC_SEQ: o_npc = w_pc_seq;
      NPC_BR:  o_npc = i_cmp_true ? w_br_target : w_pc_seq;
      NPC_J:   o_npc = w_j_target;
      NPC_JR:  o_npc = i_rs_val_d;
      default: o_npc = w_pc_seq;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_npc_stage.sv
// fetch_npc_stage: PC register, IM address and IF/ID pipeline register with one delay slot.
// Rev 1.0
`default_nettype none

module fetch_npc_stage
  import fetch_npc_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = C_PC_RESET,
  parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        cmp_true,
  input  logic [15:0] imm16_d,
  input  logic [25:0] imm26_d,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d
);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc8_d;
  logic [31:0] w_npc;

  npc_calc u_npc_calc (
    .i_pc_f     (r_pc_f),
    .i_pc_d     (r_pc_d),
    .i_npc_sel  (npc_sel),
    .i_cmp_true (cmp_true),
    .i_imm16_d  (imm16_d),
    .i_imm26_d  (imm26_d),
    .i_rs_val_d (rs_val_d),
    .o_npc      (w_npc)
  );

  // A stalled redirect is dropped here; ID re-presents it once its operands are forwarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc_f    <= PC_RESET;
      r_instr_d <= NOP_WORD;
      r_pc_d    <= 32'h0;
      r_pc8_d   <= 32'h0;
    end else if (!stall) begin
      r_pc_f    <= w_npc;
      r_instr_d <= instr_f;
      r_pc_d    <= r_pc_f;
      r_pc8_d   <= r_pc_f + 32'd8;
    end
  end

  assign pc_f    = r_pc_f;
  assign instr_d = r_instr_d;
  assign pc_d    = r_pc_d;
  assign pc8_d   = r_pc8_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_npc_stage.sv
// tb_fetch_npc_stage: directed stimulus, behavioural next-PC model plus literal anchors.
// Rev 1.0
`default_nettype none

module tb_fetch_npc_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        cmp_true;
  logic [15:0] imm16_d;
  logic [25:0] imm26_d;
  logic [31:0] rs_val_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;

  int n_pass = 0;
  int n_total = 0;

  fetch_npc_stage dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .cmp_true (cmp_true),
    .imm16_d  (imm16_d),
    .imm26_d  (imm26_d),
    .rs_val_d (rs_val_d),
    .instr_f  (instr_f),
    .pc_f     (pc_f),
    .instr_d  (instr_d),
    .pc_d     (pc_d),
    .pc8_d    (pc8_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign instr_f = mem(pc_f);

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    longint off;
    logic [31:0] nxt;
    if (reset === 1'b0) begin
      m_pc = 32'h3000; m_instr = 32'h0; m_pcd = 32'h0; m_pc8 = 32'h0;
      m_valid = 1'b1;
    end else if (m_valid && stall === 1'b0) begin
      nxt = m_pc + 4;
      if (npc_sel == 2'd1 && cmp_true) begin
        off = longint'($signed(imm16_d)) * 4;
        nxt = 32'(longint'(m_pcd) + 4 + off);
      end else if (npc_sel == 2'd2) begin
        nxt = (m_pcd & 32'hF000_0000) | (32'(imm26_d) * 4);
      end else if (npc_sel == 2'd3) begin
        nxt = rs_val_d;
      end
      m_instr = mem(m_pc);
      m_pcd   = m_pc;
      m_pc8   = m_pc + 8;
      m_pc    = nxt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model pc_f", pc_f, m_pc);
      chk("model instr_d", instr_d, m_instr);
      chk("model pc_d", pc_d, m_pcd);
      chk("model pc8_d", pc8_d, m_pc8);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic [1:0] sel, input logic c,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
    stall = s; npc_sel = sel; cmp_true = c; imm16_d = i16; imm26_d = i26; rs_val_d = rs;
  endtask

  // One reset edge, then n sequential edges.
  task automatic reset_then_run(input int n);
    reset = 1'b0;
    set_in(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    step();
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  sel;
    logic        c;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0, 32'h0};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 16'h7FFF, 26'h0, 32'h0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 16'h8000, 26'h0, 32'h0};
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 16'h0000, 26'h0, 32'hDEAD_BEE0};
    vecs[5]  = '{1'b0, 2'b11, 1'b0, 16'h0000, 26'h0, 32'hFFFF_FFFC};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0, 32'h0};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0, 32'h0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 16'h0000, 26'h3FF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 16'h0000, 26'h0, 32'h0000_0003};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 16'h0010, 26'h0, 32'h0};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0, 32'h0};

    reset = 1'b0;
    set_in(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    @(negedge clk);
    step();
    chk("reset pc_f", pc_f, 32'h3000);
    chk("reset instr_d", instr_d, 32'h0);
    chk("reset pc_d", pc_d, 32'h0);
    chk("reset pc8_d", pc8_d, 32'h0);

    reset = 1'b1;
    step();
    chk("seq1 pc_f", pc_f, 32'h3004);
    chk("seq1 pc_d", pc_d, 32'h3000);
    chk("seq1 pc8_d", pc8_d, 32'h3008);
    chk("seq1 instr_d", instr_d, mem(32'h3000));
    step();
    chk("seq2 pc_f", pc_f, 32'h3008);

    // Taken branch backwards from 0x3010.
    reset_then_run(5);
    chk("br setup pc_d", pc_d, 32'h3010);
    set_in(1'b0, 2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0);
    step();
    chk("br taken pc_f", pc_f, 32'h3004);
    chk("br delay slot pc_d", pc_d, 32'h3014);

    // Same setup, not taken.
    reset_then_run(5);
    set_in(1'b0, 2'b01, 1'b0, 16'hFFFC, 26'h0, 32'h0);
    step();
    chk("br not-taken pc_f", pc_f, 32'h3018);

    // j then jr.
    reset_then_run(9);
    chk("j setup pc_d", pc_d, 32'h3020);
    set_in(1'b0, 2'b10, 1'b0, 16'h0, 26'h000_0C10, 32'h0);
    step();
    chk("j pc_f", pc_f, 32'h3040);
    set_in(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3100);
    step();
    chk("jr pc_f", pc_f, 32'h3100);
    chk("jr pc_d", pc_d, 32'h3040);

    // Stalled redirect is held off until the stall drops.
    reset_then_run(5);
    set_in(1'b1, 2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0);
    step();
    chk("stall1 pc_f", pc_f, 32'h3014);
    chk("stall1 pc_d", pc_d, 32'h3010);
    step();
    chk("stall2 pc_f", pc_f, 32'h3014);
    chk("stall2 instr_d", instr_d, mem(32'h3010));
    stall = 1'b0;
    step();
    chk("unstall pc_f", pc_f, 32'h3004);
    chk("unstall pc_d", pc_d, 32'h3014);

    // Reset wins over a concurrent jr.
    set_in(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_4000);
    reset = 1'b0;
    step();
    chk("rst-jr pc_f", pc_f, 32'h3000);
    chk("rst-jr instr_d", instr_d, 32'h0);
    reset = 1'b1;

    // Mixed directed sequence checked by the model, including wrap and offset extremes.
    set_in(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].s, vecs[i].sel, vecs[i].c, vecs[i].i16, vecs[i].i26, vecs[i].rs);
      step();
    end
    chk("wrap-then-j pc_f", pc_f, m_pc);

    set_in(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_npc_stage.md
Name: fetch_npc_stage

Overview:
- IF stage plus the IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory address.
- Consumes the branch-compare result (cmp_true) and the jump operands from the ID stage, and selects the next PC with one architectural delay slot.
- Drives the IF/ID register contents (instruction, PC, PC+8) into the ID stage.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- NOP_WORD, 32'h0000_0000, instr_d value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; sampled only on the rising clk edge.
- stall  input  1  from the hazard unit; 1 = hold PC and IF/ID this cycle.
- npc_sel  input  2  ID-stage control: 2'b00 sequential, 2'b01 conditional branch, 2'b10 j/jal, 2'b11 jr.
- cmp_true  input  1  branch condition result for the instruction currently in ID.
- imm16_d  input  16  ID instruction [15:0].
- imm26_d  input  26  ID instruction [25:0].
- rs_val_d  input  32  forwarded GPR[rs] in ID (jr target).
- instr_f  input  32  instruction-memory read data at pc_f (combinational IM).
- pc_f  output  32  current fetch PC, drives the IM address.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC.
- pc8_d  output  32  IF/ID PC+8 (link value).

Behaviour:
- All state updates on the rising clk edge. Priority: reset low > stall > next-PC select.
- Reset (reset==0 at an edge):
  - pc_f = PC_RESET
  - instr_d = NOP_WORD
  - pc_d = 32'h0
  - pc8_d = 32'h0
  - This applies mid-operation too: any in-flight redirect is discarded.
- Stall=1: pc_f, instr_d, pc_d and pc8_d all hold. A redirect presented in the same cycle is ignored; ID re-presents it once stall drops, because its operands may not be forwarded yet.
- Normal cycle:
  - IF/ID loads instr_f, pc_f, and pc_f+8.
  - pc_f loads npc, selected by npc_sel:
    - 00: pc_f + 4
    - 01, cmp_true=1: pc_d + 4 + (sign_extend(imm16_d) << 2)
    - 01, cmp_true=0: pc_f + 4
    - 10: {pc_d[31:28], imm26_d, 2'b00}
    - 11: rs_val_d, taken unmodified (no alignment check and no exception in this design)
- Delay slot: while a branch/jump is in ID, its delay slot (pc_d+4) is in IF. The delay slot is always latched into IF/ID; the target is fetched on the following cycle. This block performs no flush.
- Arithmetic: all adds are 32-bit modulo 2^32. The branch offset range is -131072..+131068 bytes. PC wrap-around is silent.
- pc_f changes only at clock edges. pc_f, instr_d, pc_d and pc8_d are registered; there is no combinational path from inputs to outputs.
- Invalid npc_sel cannot occur (2-bit encoding is fully decoded).

Decomposition:
- Shared macro/constant header:
  - PC_RESET value
  - NOP_WORD
  - npc_sel encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR)
  - These encodings are shared with the ID-stage controller.
- One combinational sub-module, npc_calc:
  - Inputs: pc_f, pc_d, npc_sel, cmp_true, imm16_d, imm26_d, rs_val_d.
  - Output: npc.
- Top level holds the PC register and the IF/ID register.

Test Plan:
- Reset: hold reset=0 for 2 edges, then release with npc_sel=00 -> pc_f=0x3000 and instr_d=0 while in reset; after release pc_f steps 0x3004, 0x3008; pc8_d=0x3008 when pc_d=0x3000.
- Taken branch: pc_d=0x3010, pc_f=0x3014, npc_sel=01, cmp_true=1, imm16=0xFFFC -> next pc_f=0x3004; IF/ID holds delay slot pc_d=0x3014.
- Not-taken branch: same setup with cmp_true=0 -> next pc_f=0x3018.
- Jumps:
  - j with pc_d=0x3020, imm26=0x0000C10 -> next pc_f=0x0000_3040.
  - jr with rs_val_d=0x0000_3100 -> next pc_f=0x3100.
- Stall plus redirect: stall=1 with npc_sel=01, cmp_true=1 for 2 cycles -> pc_f and IF/ID unchanged; stall=0 on the third cycle -> branch target loaded.
- Reset mid-redirect: reset=0 on the same edge as npc_sel=11, rs_val_d=0x4000 -> pc_f=0x3000, instr_d=0.
